pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/adder_internal.sv | 25 ++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared widths, FSM state encoding and the wrap-carry helper for the
// program-counter sequencer.
package pc_sequencer_pkg;

  localparam int PC_W   = 8;
  localparam int STEP_W = 3;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FETCH_ENC = 2'd1;
  localparam logic [1:0] ST_STALL_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_STALL = ST_STALL_ENC
  } state_t;

  // True when pc + step does not fit in PC_W bits (9-bit sum above 255).
  function automatic logic carry_out(input logic [PC_W-1:0]   a,
                                     input logic [STEP_W-1:0] b);
    logic [PC_W:0] wide;
    wide = {1'b0, a} + {{(PC_W - STEP_W + 1){1'b0}}, b};
    return wide > {1'b0, {PC_W{1'b1}}};
  endfunction

endpackage

// File: rtl/adder_internal.sv
// Ripple-carry adder: sum = a + zero-extended b, truncated to W bits.
module adder_internal #(
  parameter int W  = 8,
  parameter int BW = 3
) (
  input  logic [W-1:0]  a,
  input  logic [BW-1:0] b,
  output logic [W-1:0]  sum
);

  logic [W-1:0] b_ext;
  logic [W-1:0] carry;

  assign b_ext    = {{(W - BW){1'b0}}, b};
  assign carry[0] = 1'b0;

  // Carry out of the top bit is dropped; the caller derives wrap separately.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi] = a[gi] ^ b_ext[gi] ^ carry[gi];
    if (gi < W - 1) begin : g_carry
      assign carry[gi+1] = (a[gi] & b_ext[gi]) | (carry[gi] & (a[gi] ^ b_ext[gi]));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch program counter sequencer: IDLE/FETCH/STALL FSM with
// step increment, pending branch redirect and a one-cycle wrap pulse.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic [STEP_W-1:0] step,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              wrap
);

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pend_target_reg;
  logic            pend_valid_reg;
  logic            imem_req_reg;
  logic            busy_reg;
  logic            wrap_reg;

  logic [PC_W-1:0] inc_sum;
  logic            inc_carry;

  adder_internal #(
    .W  (PC_W),
    .BW (STEP_W)
  ) u_inc (
    .a   (pc_reg),
    .b   (step),
    .sum (inc_sum)
  );

  assign inc_carry = carry_out(pc_reg, step);

  // All outputs come straight from registers: no path from imem_ack to imem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      pend_target_reg <= '0;
      pend_valid_reg  <= 1'b0;
      imem_req_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      wrap_reg        <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (br_valid) begin
            pc_reg         <= br_target;
            pend_valid_reg <= 1'b0;
          end
          if (start && !halt) begin
            state_reg    <= ST_FETCH;
            imem_req_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (imem_ack) begin
            pend_valid_reg <= 1'b0;
            // A same-cycle redirect beats an older pending one, which beats step.
            if (br_valid) begin
              pc_reg <= br_target;
            end else if (pend_valid_reg) begin
              pc_reg <= pend_target_reg;
            end else begin
              pc_reg   <= inc_sum;
              wrap_reg <= inc_carry;
            end
            if (halt) begin
              state_reg    <= ST_IDLE;
              imem_req_reg <= 1'b0;
              busy_reg     <= 1'b0;
            end else if (stall) begin
              state_reg    <= ST_STALL;
              imem_req_reg <= 1'b0;
            end
          end else if (br_valid) begin
            pend_valid_reg  <= 1'b1;
            pend_target_reg <= br_target;
          end
        end

        ST_STALL: begin
          if (br_valid) begin
            pc_reg         <= br_target;
            pend_valid_reg <= 1'b0;
          end
          if (!stall) begin
            if (halt) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg    <= ST_FETCH;
              imem_req_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          imem_req_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign busy      = busy_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle comparison against a behavioural
// model plus hand-computed checkpoints for the key scenarios.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt, stall, br_valid, imem_ack;
  logic [2:0] step;
  logic [7:0] br_target;
  logic       imem_req, busy, wrap;
  logic [7:0] imem_addr, pc;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .stall     (stall),
    .step      (step),
    .br_valid  (br_valid),
    .br_target (br_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .pc        (pc),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end else if (verbose) begin
      $display("[%0t] %s = %0h ok", $time, nm, act);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 fetching, 2 stalled.
  int m_mode, m_pc, m_tgt;
  bit m_pend, m_wrap;

  always @(posedge clk or negedge rst_n) begin : model
    int sum;
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 0; m_pend <= 0; m_wrap <= 0;
    end else begin
      m_wrap <= 0;
      if (m_mode == 0) begin
        if (br_valid) begin m_pc <= int'(br_target); m_pend <= 0; end
        if (start && !halt) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (imem_ack) begin
          m_pend <= 0;
          if (br_valid) m_pc <= int'(br_target);
          else if (m_pend) m_pc <= m_tgt;
          else begin
            sum = m_pc + int'(step);
            m_pc   <= sum % 256;
            m_wrap <= (sum > 255);
          end
          m_mode <= halt ? 0 : (stall ? 2 : 1);
        end else if (br_valid) begin
          m_pend <= 1; m_tgt <= int'(br_target);
        end
      end else begin
        if (br_valid) begin m_pc <= int'(br_target); m_pend <= 0; end
        if (!stall) m_mode <= halt ? 0 : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_req",  32'(imem_req),  32'(m_mode == 1), 1'b0);
      chk("cyc_addr", 32'(imem_addr), 32'(m_pc),        1'b0);
      chk("cyc_pc",   32'(pc),        32'(m_pc),        1'b0);
      chk("cyc_busy", 32'(busy),      32'(m_mode != 0), 1'b0);
      chk("cyc_wrap", 32'(wrap),      32'(m_wrap),      1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 0; halt = 0; stall = 0; br_valid = 0; imem_ack = 0;
    step = 3'd0; br_target = 8'h00;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_req",  32'(imem_req), 32'h0, 1'b1);
    chk("rst_pc",   32'(pc),       32'h0, 1'b1);
    chk("rst_busy", 32'(busy),     32'h0, 1'b1);
    chk("rst_wrap", 32'(wrap),     32'h0, 1'b1);

    // Sequential fetch, ack every cycle
    rst_n = 1'b1; start = 1; step = 3'd1; imem_ack = 1;
    tick(); chk("seq_addr0", 32'(imem_addr), 32'h00, 1'b1);
    chk("seq_req", 32'(imem_req), 32'h1, 1'b1);
    tick(); chk("seq_addr1", 32'(imem_addr), 32'h01, 1'b1);
    tick(); chk("seq_addr2", 32'(imem_addr), 32'h02, 1'b1);
    tick(); chk("seq_addr3", 32'(imem_addr), 32'h03, 1'b1);

    // Halt at ack, then redirect while idle
    start = 0; halt = 1;
    tick(); chk("halt_req", 32'(imem_req), 32'h0, 1'b1);
    chk("halt_pc", 32'(pc), 32'h04, 1'b1);
    halt = 0; imem_ack = 0; br_valid = 1; br_target = 8'hFE;
    tick(); chk("idle_br_pc", 32'(pc), 32'hFE, 1'b1);
    br_valid = 0; start = 1; step = 3'd3;
    tick(); chk("fetch_fe", 32'(imem_addr), 32'hFE, 1'b1);

    // Wrap: FE + 3 -> 01
    start = 0; imem_ack = 1;
    tick(); chk("wrap_pc", 32'(pc), 32'h01, 1'b1);
    chk("wrap_pulse", 32'(wrap), 32'h1, 1'b1);
    imem_ack = 0;
    tick(); chk("wrap_clear", 32'(wrap), 32'h0, 1'b1);

    // Pending redirect held until ack
    br_valid = 1; br_target = 8'h10; imem_ack = 1;
    tick(); chk("br_to_10", 32'(imem_addr), 32'h10, 1'b1);
    imem_ack = 0; br_target = 8'h80;
    tick(); chk("pend_hold1", 32'(imem_addr), 32'h10, 1'b1);
    br_valid = 0;
    tick(); chk("pend_hold2", 32'(imem_addr), 32'h10, 1'b1);
    imem_ack = 1;
    tick(); chk("pend_apply", 32'(imem_addr), 32'h80, 1'b1);

    // Coincident redirect beats older pending target and step
    imem_ack = 0; br_valid = 1; br_target = 8'h55; step = 3'd2;
    tick(); chk("pend55_hold", 32'(imem_addr), 32'h80, 1'b1);
    imem_ack = 1; br_target = 8'h40;
    tick(); chk("coinc_addr", 32'(imem_addr), 32'h40, 1'b1);
    chk("coinc_wrap", 32'(wrap), 32'h0, 1'b1);

    // Stall at ack: 05 + 4 -> 09
    br_target = 8'h05;
    tick(); chk("br_to_05", 32'(pc), 32'h05, 1'b1);
    br_valid = 0; step = 3'd4; stall = 1;
    tick(); chk("stall_req", 32'(imem_req), 32'h0, 1'b1);
    chk("stall_pc", 32'(pc), 32'h09, 1'b1);
    chk("stall_busy", 32'(busy), 32'h1, 1'b1);
    tick(); chk("stall_ack_ignored", 32'(pc), 32'h09, 1'b1);
    stall = 0; imem_ack = 0;
    tick(); chk("unstall_req", 32'(imem_req), 32'h1, 1'b1);
    chk("unstall_addr", 32'(imem_addr), 32'h09, 1'b1);

    // Reset mid-fetch with ack asserted
    imem_ack = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req",  32'(imem_req), 32'h0, 1'b1);
    chk("mrst_pc",   32'(pc),       32'h0, 1'b1);
    chk("mrst_busy", 32'(busy),     32'h0, 1'b1);
    tick(); chk("mrst_hold_pc", 32'(pc), 32'h0, 1'b1);
    rst_n = 1'b1; imem_ack = 0;
    tick(); tick(); chk("post_rst_noreq", 32'(imem_req), 32'h0, 1'b1);
    start = 1;
    tick(); chk("restart_req", 32'(imem_req), 32'h1, 1'b1);

    // step = 0 refetches the same address
    start = 0; step = 3'd0; imem_ack = 1;
    tick(); chk("step0_addr", 32'(imem_addr), 32'h00, 1'b1);
    step = 3'd5;
    tick(); chk("step5_addr", 32'(imem_addr), 32'h05, 1'b1);
    halt = 1;
    tick(); chk("final_busy", 32'(busy), 32'h0, 1'b1);
    chk("final_pc", 32'(pc), 32'h0A, 1'b1);
    halt = 0; imem_ack = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
